// File: rtl/sha256_msg_sched.sv
`timescale 1ns/1ps
// sha256_msg_sched
// Producer side of the SHA-256 core's per-round word interface. It takes a
// 512-bit block as 16 serial words over valid/ready, emits the load-IV pulse
// and round enable, and supplies Wt/Kt for all 64 rounds. W16..W63 are
// expanded on the fly from a 16-word sliding window.
// Optional feature macro: SHA256_SCHED_STALL_EN adds stall_i, which freezes
// the expansion rounds and back-pressures the load rounds.
module sha256_msg_sched #(
  parameter int NUM_ROUNDS = 64,  // FIPS 180-4 value; only 64 is legal
  parameter int WIN_DEPTH  = 16   // schedule window depth; only 16 is legal
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid_i,
  input  logic [31:0] blk_word_i,
  input  logic        blk_first_i,
`ifdef SHA256_SCHED_STALL_EN
  input  logic        stall_i,
`endif
  output logic        blk_ready_o,
  output logic        ld_o,
  output logic        en_o,
  output logic [31:0] wt_o,
  output logic [31:0] kt_o,
  output logic [5:0]  round_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    LOAD   = 3'd2,
    EXPAND = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [5:0] LAST_LOAD  = 6'(WIN_DEPTH - 1);
  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  t;
  logic [31:0] win [WIN_DEPTH];
  logic [31:0] w_new;
  logic        advance;
  logic        stall;

`ifdef SHA256_SCHED_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Round constant ROM: first 32 bits of the fractional parts of the cube
  // roots of the first 64 primes.
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      default: k = 32'hc67178f2;  // idx 63
    endcase
    return k;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window slot 0 holds W[t-16] and slot WIN_DEPTH-1 holds W[t-1].
  assign w_new = sig1(win[WIN_DEPTH-2]) + win[WIN_DEPTH-7]
               + sig0(win[1]) + win[0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode.
  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    blk_ready_o = 1'b0;
    ld_o        = 1'b0;
    en_o        = 1'b0;
    wt_o        = '0;
    kt_o        = '0;
    done_o      = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        // The word is only looked at here, never consumed.
        if (blk_valid_i) state_nxt = blk_first_i ? INIT : LOAD;
      end
      INIT: begin
        ld_o      = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        blk_ready_o = ~stall;
        if (blk_valid_i && !stall) begin
          en_o    = 1'b1;
          wt_o    = blk_word_i;
          kt_o    = k_rom(t);
          advance = 1'b1;
          if (t == LAST_LOAD) state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        // While stalled the window and t are frozen, so Wt/Kt simply hold.
        wt_o = w_new;
        kt_o = k_rom(t);
        if (!stall) begin
          en_o    = 1'b1;
          advance = 1'b1;
          if (t == LAST_ROUND) state_nxt = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign round_o = t;

  // Round counter: advances on every issued round, cleared in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                t <= '0;
    else if (state == DONE) t <= '0;
    else if (advance)       t <= t + 6'd1;
  end

  // Sliding window: shift in the Wt issued this round.
  // NOTE: the window is reset like ordinary state so an abandoned block
  // never leaks words into the next one and the flops stay deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) win[i] <= win[i+1];
      win[WIN_DEPTH-1] <= wt_o;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
`timescale 1ns/1ps
// tb_sha256_msg_sched
// Drives message blocks into the scheduler, compares every round against a
// plain-arithmetic message-schedule model and runs an attached SHA-256 round
// model on the DUT's Wt/Kt to confirm the "abc" working variable a.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blk_valid_i = 1'b0;
  logic [31:0] blk_word_i = '0;
  logic        blk_first_i = 1'b0;
`ifdef SHA256_SCHED_STALL_EN
  logic        stall_i = 1'b0;
`endif
  logic        blk_ready_o, ld_o, en_o, done_o;
  logic [31:0] wt_o, kt_o;
  logic [5:0]  round_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] msg    [16];
  logic [31:0] w_exp  [64];
  logic [31:0] wt_seen[64];
  logic [31:0] kt_seen[64];
  logic [31:0] hv     [8];
  logic [31:0] k_tab  [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] iv_tab [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  logic [31:0] abc_w16 [4] = '{32'h61626380, 32'h000f0000, 32'h7da86405, 32'h600003c6};

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk         (clk),
    .rst         (rst),
    .blk_valid_i (blk_valid_i),
    .blk_word_i  (blk_word_i),
    .blk_first_i (blk_first_i),
`ifdef SHA256_SCHED_STALL_EN
    .stall_i     (stall_i),
`endif
    .blk_ready_o (blk_ready_o),
    .ld_o        (ld_o),
    .en_o        (en_o),
    .wt_o        (wt_o),
    .kt_o        (kt_o),
    .round_o     (round_o),
    .done_o      (done_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  task automatic build_schedule();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w_exp[t] = msg[t];
      else        w_exp[t] = ss1(w_exp[t-2]) + w_exp[t-7] + ss0(w_exp[t-15]) + w_exp[t-16];
    end
  endtask

  task automatic core_round(input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = hv[7] + bs1(hv[4]) + ((hv[4] & hv[5]) ^ (~hv[4] & hv[6])) + k + w;
    t2 = bs0(hv[0]) + ((hv[0] & hv[1]) ^ (hv[0] & hv[2]) ^ (hv[1] & hv[2]));
    hv[7] = hv[6]; hv[6] = hv[5]; hv[5] = hv[4]; hv[4] = hv[3] + t1;
    hv[3] = hv[2]; hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = t1 + t2;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) msg[i] = $urandom();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_stall(input bit v);
`ifdef SHA256_SCHED_STALL_EN
    stall_i = v;
`else
    if (v) $error("FAIL stall_request observed=1 expected=0");
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {22'd0, blk_ready_o, ld_o, en_o, done_o, round_o}, 32'd0);
    check({tag, "_wt"}, wt_o, 32'd0);
    check({tag, "_kt"}, kt_o, 32'd0);
  endtask

  // mode: 0 continuous valid, 1 valid toggling 1/0, 2 random valid.
  // exp_lat < 0 skips the latency check; abort_at >= 0 resets at that round.
  task automatic run_block(input bit first, input int mode, input int stall_at,
                           input int stall_len, input int abort_at, input int exp_lat);
    int idx = 0, en_cnt = 0, ld_cnt = 0, cyc = 0, stall_left = stall_len;
    bit got_done = 0, stalling, hs, v;
    build_schedule();
    blk_first_i = first;
    while (!got_done && cyc < 400) begin
      if (abort_at >= 0 && en_cnt == abort_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("abort_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        blk_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("abort_no_done", {31'd0, done_o}, 32'd0);
          check("abort_no_en", {31'd0, en_o}, 32'd0);
          @(posedge clk); #1;
        end
        return;
      end
      v = (mode == 0) || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(0, 2) != 0);
      blk_valid_i = (idx < 16) && v;
      blk_word_i  = blk_valid_i ? msg[idx] : $urandom();
      stalling = (stall_len > 0) && (en_cnt == stall_at) && (stall_left > 0);
      if (stalling) stall_left--;
      set_stall(stalling);
      @(negedge clk);
      hs = blk_valid_i && blk_ready_o;
      if (cyc == 0) check("ready_in_idle", {31'd0, blk_ready_o}, 32'd0);
      check("ld_en_exclusive", {31'd0, ld_o & en_o}, 32'd0);
      if (ld_o) begin
        ld_cnt++;
        for (int i = 0; i < 8; i++) hv[i] = iv_tab[i];
      end
      if (en_cnt < 16) check("en_vs_handshake", {31'd0, en_o}, {31'd0, hs});
      if (stalling) begin
        check("en_during_stall", {31'd0, en_o}, 32'd0);
        check("wt_held_stall", wt_o, w_exp[stall_at]);
      end else if (en_o) begin
        check("round", {26'd0, round_o}, 32'(en_cnt));
        check("wt", wt_o, w_exp[en_cnt]);
        check("kt", kt_o, k_tab[en_cnt]);
        wt_seen[en_cnt] = wt_o;
        kt_seen[en_cnt] = kt_o;
        core_round(kt_o, wt_o);
        en_cnt++;
      end else begin
        check("wt_idle_zero", wt_o, 32'd0);
        check("kt_idle_zero", kt_o, 32'd0);
      end
      if (hs) idx++;
      if (done_o) begin
        got_done = 1;
        check("rounds_at_done", 32'(en_cnt), 32'd64);
        check("ld_pulses", 32'(ld_cnt), first ? 32'd1 : 32'd0);
        if (exp_lat >= 0) check("done_latency", 32'(cyc), 32'(exp_lat));
      end
      cyc++;
      @(posedge clk); #1;
    end
    set_stall(1'b0);
    blk_valid_i = 1'b0;
    if (!got_done) check("done_timeout", 32'(cyc), 32'(exp_lat));
    @(negedge clk);
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    check("idle_after_done", {30'd0, blk_ready_o, en_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");

    // "abc", first block, continuous valid.
    set_abc();
    run_block(1'b1, 0, 0, 0, -1, 66);
    for (int i = 0; i < 4; i++) check("abc_w16_19", wt_seen[16+i], abc_w16[i]);
    check("abc_k0", kt_seen[0], 32'h428a2f98);
    check("abc_k63", kt_seen[63], 32'hc67178f2);
    check("abc_core_a", hv[0], 32'h506e3058);

    // Same block with valid toggling during LOAD.
    set_abc();
    run_block(1'b1, 1, 0, 0, -1, -1);
    check("abc_toggle_core_a", hv[0], 32'h506e3058);

    // Continuation block: no load pulse, 65 cycles to done.
    set_random();
    run_block(1'b0, 0, 0, 0, -1, 65);

    // Random first block with random bubbles.
    set_random();
    run_block(1'b1, 2, 0, 0, -1, -1);

    // Reset asserted mid-expansion at t=30, then a clean block.
    set_random();
    run_block(1'b1, 0, 0, 0, 30, -1);
    set_random();
    run_block(1'b0, 0, 0, 0, -1, 65);
    set_random();
    run_block(1'b1, 2, 0, 0, -1, -1);

`ifdef SHA256_SCHED_STALL_EN
    // Five stall cycles at t=40 delay done by exactly five cycles.
    set_random();
    run_block(1'b1, 0, 40, 5, -1, 71);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Producer side of the hash core's per-round word interface. Accepts a 512-bit block as 16 serial 32-bit words over a valid/ready handshake.
- Drives the core's load pulse, round enable, Wt and Kt for all 64 rounds.
- Keeps the 16-word sliding window and computes W16..W63 on the fly.
- Sits between the padding/block buffer and the hash core; its outputs connect directly to ld_i, en_i, Wt_i and Kt_i.

Parameters:
- NUM_ROUNDS, 64, rounds per block. Fixed by FIPS 180-4; only 64 is legal.
- WIN_DEPTH, 16, schedule window depth in words. Fixed; only 16 is legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- blk_valid_i  in  1  upstream word valid.
- blk_word_i  in  32  upstream message word, big-endian word order, M0 first.
- blk_first_i  in  1  qualifies the first word of the first block of a message; sampled only in IDLE.
- blk_ready_o  out  1  word accepted when valid and ready are both 1.
- ld_o  out  1  load-IV pulse to the core.
- en_o  out  1  round enable to the core.
- wt_o  out  32  Wt for the current round.
- kt_o  out  32  Kt for the current round.
- round_o  out  6  current round index t.
- done_o  out  1  one-cycle pulse after round 63.

Behaviour:
- One clock domain (clk). Reset asynchronous active-high (rst).
- Reset values: state=IDLE, round counter=0, window W[0..15]=0. All outputs 0.
- The same reset behaviour applies when rst asserts mid-block: the in-flight block is abandoned and no done_o is issued.
- FSM states: IDLE, INIT, LOAD, EXPAND, DONE.
- IDLE:
  - blk_ready_o=0.
  - blk_valid_i=1 and blk_first_i=1 -> INIT.
  - blk_valid_i=1 and blk_first_i=0 -> LOAD (continuation block; core state is not reloaded).
- INIT: ld_o=1 for exactly one cycle, en_o=0, no word consumed -> LOAD.
- LOAD (rounds 0..15):
  - blk_ready_o=1.
  - On handshake: en_o=1, wt_o=blk_word_i (combinational passthrough), kt_o=K[t], round_o=t.
  - The word shifts into the window and t increments.
  - When blk_valid_i=0: en_o=0, no advance (upstream bubbles stall rounds).
  - Handshake at t=15 -> EXPAND.
- EXPAND (rounds 16..63):
  - blk_ready_o=0, en_o=1 every cycle.
  - wt_o = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - s0(x) = rotr7 ^ rotr18 ^ shr3. s1(x) = rotr17 ^ rotr19 ^ shr10.
  - The window shifts with the new Wt each cycle.
  - After t=63 -> DONE.
- DONE: done_o=1 for one cycle, en_o=0, t cleared to 0 -> IDLE.
- The block is accepted again no earlier than the cycle after DONE.
- kt_o comes from a 64-entry constant ROM indexed by t: K[0]=428a2f98, K[63]=c67178f2.
- Outside LOAD handshakes and EXPAND: kt_o and wt_o are don't-care, but held at 0.
- ld_o and en_o are never both 1 in the same cycle.
- Best-case latency with continuous valid and a first block: 1 (INIT) + 16 + 48 + 1 (DONE) = 66 cycles from the first word presented to done_o.

Optional Feature:
- Macro: SHA256_SCHED_STALL_EN.
- When defined:
  - Extra input port stall_i (1 bit).
  - In EXPAND, stall_i=1 forces en_o=0 and freezes t, the window and wt_o.
  - In LOAD, stall_i=1 forces blk_ready_o=0.
  - INIT and DONE are unaffected.
- When undefined: the port is absent and EXPAND runs 48 back-to-back cycles.

Test Plan:
- Reset: assert rst mid-EXPAND (t=30) -> all outputs 0 immediately, state IDLE. The next block starts from t=0 with a zero window.
- "abc" block, first=1, continuous valid:
  - Words: W0=61626380, W1..W14=0, W15=00000018.
  - Required: ld_o pulse, then en_o for 64 cycles.
  - wt_o at t=16..19 = 61626380, 000f0000, 7da86405, 600003c6.
  - kt_o at t=0 = 428a2f98, at t=63 = c67178f2.
  - done_o one cycle after t=63.
- Same block with valid toggling 1/0 during LOAD -> en_o only on handshakes, identical Wt sequence, round_o never skips.
- Continuation block (blk_first_i=0) -> no ld_o, LOAD entered directly, 65 cycles to done_o.
- With the core attached, "abc" -> after round 63, core a=506e3058.
- SHA256_SCHED_STALL_EN: stall_i=1 for 5 cycles at t=40 -> en_o=0 and wt_o held for those cycles, t=40 resumes, done_o delayed by exactly 5 cycles.
